// File: rtl/usb_rw_burst_fsm.sv
// -----------------------------------------------------------------------------
// usb_rw_burst_fsm
// USB host read/write transaction sequencer sitting between the host tasks and
// the protocol FSM. A transaction is a mem-page OUT transaction (OUT_TOK +
// OUT_DATA carrying the page) followed by 1..MAX_BURST data beats, each one a
// token (IN_TOK for read, OUT_TOK for write) plus a data message (IN_DATA or
// OUT_DATA). A data phase that times out is retried up to MAX_RETRY times
// (the token is re-issued) before the whole transaction is aborted.
//
// Ports
//   clk, rst_L               clock, asynchronous active-low reset
//   start_read/start_write   transaction request levels, sampled in IDLE
//   mem_page, burst_len      latched when a start is taken
//   wr_data                  write payload for beat wr_beat
//   wr_beat, wr_ack          current beat index / 1-cycle beat-delivered pulse
//   rd_data, rd_valid        read beat payload / 1-cycle beat-received pulse
//   busy, done, success      status; success is qualified by done
//   retry_total              saturating retry count of current/last transaction
//   protocol_free, timeout   protocol FSM handshake
//   rw_din                   data returned by an IN_DATA message
//   msg_type, rw_dout        combinational message request to the protocol FSM
// -----------------------------------------------------------------------------
module usb_rw_burst_fsm #(
  parameter int DATA_W    = 64,
  parameter int PAGE_W    = 16,
  parameter int MAX_BURST = 4,
  parameter int MAX_RETRY = 3,
  localparam int BW = $clog2(MAX_BURST + 1),
  localparam int RW = $clog2(MAX_RETRY + 2)
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              start_read,
  input  logic              start_write,
  input  logic [PAGE_W-1:0] mem_page,
  input  logic [BW-1:0]     burst_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic [BW-1:0]     wr_beat,
  output logic              wr_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              success,
  output logic [7:0]        retry_total,
  input  logic              protocol_free,
  input  logic              timeout,
  input  logic [DATA_W-1:0] rw_din,
  output logic [2:0]        msg_type,
  output logic [DATA_W-1:0] rw_dout
);

  localparam logic [2:0] MSG_NONE     = 3'b000;
  localparam logic [2:0] MSG_IN_TOK   = 3'b001;
  localparam logic [2:0] MSG_OUT_TOK  = 3'b010;
  localparam logic [2:0] MSG_OUT_DATA = 3'b011;
  localparam logic [2:0] MSG_IN_DATA  = 3'b100;

  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PG_TOK = 3'd1,
    ST_PG_DAT = 3'd2,
    ST_PG_RTY = 3'd3,
    ST_BT_TOK = 3'd4,
    ST_BT_DAT = 3'd5,
    ST_BT_RTY = 3'd6,
    ST_ABORT  = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [PAGE_W-1:0]   r_page;
  logic [BW-1:0]       r_len;
  logic                r_is_read;
  logic [BW-1:0]       r_beat;
  logic [RW-1:0]       r_retry;
  logic [7:0]          r_retry_total;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_wr_ack;
  logic                r_done;
  logic                r_success;

  logic                w_start_req;
  logic                w_take_start;
  logic                w_in_dat;
  logic                w_retry;
  logic                w_pg_ok;
  logic                w_beat_ok;
  logic                w_is_last;
  logic [BW-1:0]       w_len_clamped;
  logic [2:0]          w_beat_tok;
  logic [2:0]          w_msg_type;
  logic [DATA_W-1:0]   w_rw_dout;
  logic [DATA_W-1:0]   w_page_ext;

  // ---------------------------------------------------------------------------
  // Event decodes shared by next-state, datapath and message logic
  // ---------------------------------------------------------------------------
  assign w_start_req  = start_read | start_write;
  assign w_take_start = (r_state == ST_IDLE) & w_start_req & protocol_free;
  assign w_in_dat     = (r_state == ST_PG_DAT) | (r_state == ST_BT_DAT);
  // timeout wins over protocol_free in the data-wait states
  assign w_retry      = w_in_dat & timeout & (r_retry < RETRY_MAX);
  assign w_pg_ok      = (r_state == ST_PG_DAT) & ~timeout & protocol_free;
  assign w_beat_ok    = (r_state == ST_BT_DAT) & ~timeout & protocol_free;
  assign w_is_last    = (r_beat == (r_len - BW'(1)));
  assign w_beat_tok   = r_is_read ? MSG_IN_TOK : MSG_OUT_TOK;

  always_comb begin
    w_len_clamped = burst_len;
    if (burst_len == '0) begin
      w_len_clamped = BW'(1);
    end else if (burst_len > BURST_MAX) begin
      w_len_clamped = BURST_MAX;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_take_start)  w_state_next = ST_PG_TOK;
      ST_PG_TOK: if (protocol_free) w_state_next = ST_PG_DAT;
      ST_PG_DAT: begin
        if (timeout) begin
          w_state_next = w_retry ? ST_PG_RTY : ST_ABORT;
        end else if (protocol_free) begin
          w_state_next = ST_BT_TOK;
        end
      end
      ST_PG_RTY: if (protocol_free) w_state_next = ST_PG_TOK;
      ST_BT_TOK: if (protocol_free) w_state_next = ST_BT_DAT;
      ST_BT_DAT: begin
        if (timeout) begin
          w_state_next = w_retry ? ST_BT_RTY : ST_ABORT;
        end else if (protocol_free) begin
          w_state_next = w_is_last ? ST_IDLE : ST_BT_TOK;
        end
      end
      ST_BT_RTY: if (protocol_free) w_state_next = ST_BT_TOK;
      ST_ABORT:  w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: latches, counters and registered status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_page        <= '0;
      r_len         <= '0;
      r_is_read     <= 1'b0;
      r_beat        <= '0;
      r_retry       <= '0;
      r_retry_total <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_wr_ack      <= 1'b0;
      r_done        <= 1'b0;
      r_success     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_done     <= 1'b0;

      if (w_take_start) begin
        r_page        <= mem_page;
        r_len         <= w_len_clamped;
        r_is_read     <= start_read;   // read wins when both are requested
        r_beat        <= '0;
        r_retry       <= '0;
        r_retry_total <= '0;
      end

      if (w_retry) begin
        r_retry <= r_retry + RW'(1);
        if (r_retry_total != 8'hFF) begin
          r_retry_total <= r_retry_total + 8'd1;
        end
      end

      if (w_pg_ok) begin
        r_retry <= '0;
      end

      if (w_beat_ok) begin
        r_beat  <= r_beat + BW'(1);
        r_retry <= '0;
        if (r_is_read) begin
          r_rd_data  <= rw_din;
          r_rd_valid <= 1'b1;
        end else begin
          r_wr_ack <= 1'b1;
        end
        if (w_is_last) begin
          r_done    <= 1'b1;
          r_success <= 1'b1;
        end
      end

      if (r_state == ST_ABORT) begin
        r_done    <= 1'b1;
        r_success <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Message outputs (Mealy): a message is only ever requested while the
  // protocol FSM reports free, and every request is accompanied by a state
  // change, so each one lasts exactly one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_msg_type = MSG_NONE;
    w_rw_dout  = '0;
    w_page_ext = '0;
    w_page_ext[PAGE_W-1:0] = r_page;
    case (r_state)
      ST_IDLE:   if (w_take_start)  w_msg_type = MSG_OUT_TOK;
      ST_PG_TOK: begin
        if (protocol_free) begin
          w_msg_type = MSG_OUT_DATA;
          w_rw_dout  = w_page_ext;
        end
      end
      ST_PG_DAT: if (w_pg_ok)       w_msg_type = w_beat_tok;
      ST_PG_RTY: if (protocol_free) w_msg_type = MSG_OUT_TOK;
      ST_BT_TOK: begin
        if (protocol_free) begin
          if (r_is_read) begin
            w_msg_type = MSG_IN_DATA;
          end else begin
            w_msg_type = MSG_OUT_DATA;
            w_rw_dout  = wr_data;
          end
        end
      end
      // next beat's token goes out in the same cycle the current beat completes
      ST_BT_DAT: if (w_beat_ok && !w_is_last) w_msg_type = w_beat_tok;
      ST_BT_RTY: if (protocol_free) w_msg_type = w_beat_tok;
      default:   w_msg_type = MSG_NONE;
    endcase
  end

  assign msg_type    = w_msg_type;
  assign rw_dout     = w_rw_dout;
  assign busy        = (r_state != ST_IDLE);
  assign wr_beat     = r_beat;
  assign wr_ack      = r_wr_ack;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign done        = r_done;
  assign success     = r_success;
  assign retry_total = r_retry_total;

endmodule

// File: tb/tb_usb_rw_burst_fsm.sv
// -----------------------------------------------------------------------------
// tb_usb_rw_burst_fsm
// Directed bench for usb_rw_burst_fsm. Stimulus tasks push the expected event
// stream (messages, read beats, write acks, done) into a queue before starting
// a transaction; an independent monitor pops and compares an entry whenever the
// DUT presents one of those events. A small protocol responder injects timeouts
// on selected data messages and supplies rw_din for IN_DATA.
// -----------------------------------------------------------------------------
module tb_usb_rw_burst_fsm;

  localparam int DATA_W = 64;
  localparam int PAGE_W = 16;
  localparam int BW     = 3;

  localparam logic [2:0] M_NONE     = 3'b000;
  localparam logic [2:0] M_IN_TOK   = 3'b001;
  localparam logic [2:0] M_OUT_TOK  = 3'b010;
  localparam logic [2:0] M_OUT_DATA = 3'b011;
  localparam logic [2:0] M_IN_DATA  = 3'b100;

  localparam int K_MSG  = 0;
  localparam int K_RD   = 1;
  localparam int K_ACK  = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int          kind;
    logic [2:0]  mt;
    logic [63:0] val;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic              clk;
  logic              rst_L;
  logic              start_read;
  logic              start_write;
  logic [PAGE_W-1:0] mem_page;
  logic [BW-1:0]     burst_len;
  logic [DATA_W-1:0] wr_data;
  logic [BW-1:0]     wr_beat;
  logic              wr_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              success;
  logic [7:0]        retry_total;
  logic              protocol_free;
  logic              timeout;
  logic [DATA_W-1:0] rw_din;
  logic [2:0]        msg_type;
  logic [DATA_W-1:0] rw_dout;

  // responder controls
  int          data_idx;
  int          in_idx;
  logic [31:0] to_mask;
  logic [63:0] rd_base;

  usb_rw_burst_fsm #(
    .DATA_W(DATA_W), .PAGE_W(PAGE_W), .MAX_BURST(4), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_L(rst_L),
    .start_read(start_read), .start_write(start_write),
    .mem_page(mem_page), .burst_len(burst_len),
    .wr_data(wr_data), .wr_beat(wr_beat), .wr_ack(wr_ack),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .success(success), .retry_total(retry_total),
    .protocol_free(protocol_free), .timeout(timeout),
    .rw_din(rw_din), .msg_type(msg_type), .rw_dout(rw_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write payload for the beat being sent: beat * 0x11
  initial begin
    wr_data = '0;
    forever begin
      @(wr_beat);
      wr_data = 64'h11 * 64'(wr_beat);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  function automatic void push_ev(input int kind, input logic [2:0] mt, input logic [63:0] val);
    ev_t e;
    e.kind = kind;
    e.mt   = mt;
    e.val  = val;
    sb.push_back(e);
  endfunction

  function automatic void push_msg(input logic [2:0] mt, input logic [63:0] val);
    push_ev(K_MSG, mt, val);
  endfunction

  task automatic check_ev(input int kind, input logic [2:0] mt, input logic [63:0] val);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL event: got kind=%0d mt=%0d val=%h, required no event", kind, mt, val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.mt != mt || e.val != val) begin
        n_bad++;
        $display("FAIL event: got kind=%0d mt=%0d val=%h, required kind=%0d mt=%0d val=%h",
                 kind, mt, val, e.kind, e.mt, e.val);
      end else begin
        $display("ok   event kind=%0d mt=%0d val=%h", kind, mt, val);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  // Expected stream for a read with no timeouts; rw_din for the k-th IN_DATA
  // of the transaction is rd_base + k.
  function automatic void exp_read_clean(input logic [15:0] page, input int n, input logic [63:0] base);
    push_msg(M_OUT_TOK, 64'h0);
    push_msg(M_OUT_DATA, {48'h0, page});
    push_msg(M_IN_TOK, 64'h0);
    push_msg(M_IN_DATA, 64'h0);
    for (int k = 0; k < n - 1; k++) begin
      push_msg(M_IN_TOK, 64'h0);
      push_ev(K_RD, 3'b000, base + 64'(k));
      push_msg(M_IN_DATA, 64'h0);
    end
    push_ev(K_RD, 3'b000, base + 64'(n - 1));
    push_ev(K_DONE, 3'b000, 64'h1);
  endfunction

  function automatic void exp_write_clean(input logic [15:0] page, input int n);
    push_msg(M_OUT_TOK, 64'h0);
    push_msg(M_OUT_DATA, {48'h0, page});
    push_msg(M_OUT_TOK, 64'h0);
    push_msg(M_OUT_DATA, 64'h0);
    for (int k = 0; k < n - 1; k++) begin
      push_msg(M_OUT_TOK, 64'h0);
      push_ev(K_ACK, 3'b000, 64'h0);
      push_msg(M_OUT_DATA, 64'h11 * 64'(k + 1));
    end
    push_ev(K_ACK, 3'b000, 64'h0);
    push_ev(K_DONE, 3'b000, 64'h1);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: registered outputs first (they belong to the previous cycle's
  // event), then the message requested in this cycle.
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid)           check_ev(K_RD, 3'b000, rd_data);
      if (wr_ack)             check_ev(K_ACK, 3'b000, 64'h0);
      if (done)               check_ev(K_DONE, 3'b000, {63'h0, success});
      if (msg_type != M_NONE) check_ev(K_MSG, msg_type, rw_dout);
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol responder: a data message seen this cycle decides timeout / rw_din
  // for the following (data-wait) cycle.
  // ---------------------------------------------------------------------------
  initial begin
    logic        fire;
    logic        is_in;
    logic [63:0] din;
    timeout = 1'b0;
    rw_din  = '0;
    forever begin
      @(negedge clk);
      fire  = 1'b0;
      is_in = 1'b0;
      din   = '0;
      if (msg_type == M_OUT_DATA || msg_type == M_IN_DATA) begin
        fire = (data_idx < 32) && to_mask[data_idx];
        data_idx++;
        if (msg_type == M_IN_DATA) begin
          din   = rd_base + 64'(in_idx);
          is_in = 1'b1;
          in_idx++;
        end
      end
      @(posedge clk);
      #1;
      timeout = fire;
      if (is_in) rw_din = din;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks
  // ---------------------------------------------------------------------------
  task automatic prep(input logic [31:0] mask, input logic [63:0] base);
    data_idx = 0;
    in_idx   = 0;
    to_mask  = mask;
    rd_base  = base;
  endtask

  task automatic start_txn(input logic rd, input logic wr, input logic [15:0] page, input logic [BW-1:0] len);
    @(posedge clk);
    #1;
    start_read  = rd;
    start_write = wr;
    mem_page    = page;
    burst_len   = len;
    @(posedge clk);
    #1;
    start_read  = 1'b0;
    start_write = 1'b0;
  endtask

  task automatic finish_txn(input string name, input logic [7:0] exp_rt);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s done: got no done within 300 cycles, required done pulse", name);
    end
    chk({name, " retry_total"}, 64'(retry_total), 64'(exp_rt));
    repeat (3) @(negedge clk);
    chk({name, " pending events"}, 64'(sb.size()), 64'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    logic hit;
    rst_L         = 1'b0;
    start_read    = 1'b0;
    start_write   = 1'b0;
    mem_page      = '0;
    burst_len     = '0;
    protocol_free = 1'b1;
    prep(32'h0, 64'h0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst busy",        64'(busy),        64'h0);
    chk("rst done",        64'(done),        64'h0);
    chk("rst success",     64'(success),     64'h0);
    chk("rst rd_valid",    64'(rd_valid),    64'h0);
    chk("rst wr_ack",      64'(wr_ack),      64'h0);
    chk("rst msg_type",    64'(msg_type),    64'h0);
    chk("rst rw_dout",     rw_dout,          64'h0);
    chk("rst rd_data",     rd_data,          64'h0);
    chk("rst retry_total", 64'(retry_total), 64'h0);
    chk("rst wr_beat",     64'(wr_beat),     64'h0);
    @(posedge clk);
    #1;
    rst_L = 1'b1;

    // 1: read len=1, page A5; start held while protocol busy is not taken
    prep(32'h0, 64'hDEAD);
    exp_read_clean(16'h00A5, 1, 64'hDEAD);
    @(posedge clk);
    #1;
    protocol_free = 1'b0;
    start_read    = 1'b1;
    mem_page      = 16'h00A5;
    burst_len     = 3'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1 busy while protocol busy", 64'(busy), 64'h0);
    @(posedge clk);
    #1;
    protocol_free = 1'b1;
    @(posedge clk);
    #1;
    start_read = 1'b0;
    finish_txn("t1", 8'd0);

    // 2: write len=4, payload beat*0x11
    prep(32'h0, 64'h0);
    exp_write_clean(16'h0042, 4);
    start_txn(1'b0, 1'b1, 16'h0042, 3'd4);
    finish_txn("t2", 8'd0);

    // 3: read len=2, IN_DATA of beat 1 (data msg #2) times out once
    prep(32'h4, 64'hBEEF_0000);
    push_msg(M_OUT_TOK, 64'h0);
    push_msg(M_OUT_DATA, 64'h3);
    push_msg(M_IN_TOK, 64'h0);
    push_msg(M_IN_DATA, 64'h0);
    push_msg(M_IN_TOK, 64'h0);
    push_ev(K_RD, 3'b000, 64'hBEEF_0000);
    push_msg(M_IN_DATA, 64'h0);
    push_msg(M_IN_TOK, 64'h0);
    push_msg(M_IN_DATA, 64'h0);
    push_ev(K_RD, 3'b000, 64'hBEEF_0002);
    push_ev(K_DONE, 3'b000, 64'h1);
    start_txn(1'b1, 1'b0, 16'h0003, 3'd2);
    finish_txn("t3", 8'd1);

    // 4: page OUT_DATA times out 4 times -> abort after 3 retries
    prep(32'hF, 64'h0);
    for (int k = 0; k < 4; k++) begin
      push_msg(M_OUT_TOK, 64'h0);
      push_msg(M_OUT_DATA, 64'h77);
    end
    push_ev(K_DONE, 3'b000, 64'h0);
    start_txn(1'b1, 1'b0, 16'h0077, 3'd2);
    finish_txn("t4", 8'd3);

    // 5a: both starts high, len=0 -> one read beat
    prep(32'h0, 64'h5555_0000);
    exp_read_clean(16'h0005, 1, 64'h5555_0000);
    start_txn(1'b1, 1'b1, 16'h0005, 3'd0);
    finish_txn("t5a", 8'd0);

    // 5b: len=7 clamps to 4 beats
    prep(32'h0, 64'h7000);
    exp_read_clean(16'h0006, 4, 64'h7000);
    start_txn(1'b1, 1'b0, 16'h0006, 3'd7);
    finish_txn("t5b", 8'd0);

    // 6: 4-beat write with one page retry, reset while beat 2 is in flight
    prep(32'h1, 64'h0);
    push_msg(M_OUT_TOK, 64'h0);
    push_msg(M_OUT_DATA, 64'h66);
    push_msg(M_OUT_TOK, 64'h0);
    push_msg(M_OUT_DATA, 64'h66);
    push_msg(M_OUT_TOK, 64'h0);
    push_msg(M_OUT_DATA, 64'h0);
    push_msg(M_OUT_TOK, 64'h0);
    push_ev(K_ACK, 3'b000, 64'h0);
    push_msg(M_OUT_DATA, 64'h11);
    push_msg(M_OUT_TOK, 64'h0);
    start_txn(1'b0, 1'b1, 16'h0066, 3'd4);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (wr_beat == 3'd2) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL t6 beat2: got wr_beat=%0d after 100 cycles, required 2", wr_beat);
    end
    chk("t6 retry_total before reset", 64'(retry_total), 64'h1);
    rst_L = 1'b0;
    @(negedge clk);
    chk("t6 rst busy",        64'(busy),        64'h0);
    chk("t6 rst wr_beat",     64'(wr_beat),     64'h0);
    chk("t6 rst wr_ack",      64'(wr_ack),      64'h0);
    chk("t6 rst done",        64'(done),        64'h0);
    chk("t6 rst msg_type",    64'(msg_type),    64'h0);
    chk("t6 rst retry_total", 64'(retry_total), 64'h0);
    repeat (2) @(negedge clk);
    chk("t6 pending after reset", 64'(sb.size()), 64'h0);
    @(posedge clk);
    #1;
    rst_L = 1'b1;
    prep(32'h0, 64'h0);
    exp_write_clean(16'h0009, 2);
    start_txn(1'b0, 1'b1, 16'h0009, 3'd2);
    finish_txn("t6 restart", 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
